// File: rtl/fpadd_sched_pkg.sv
// Shared FP32 definitions and sizing helpers for the FP adder slice.
package fpadd_sched_pkg;

   localparam int FP_W     = 32;
   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;
   localparam int FP_BIAS  = 127;

   // Width of an owner tag for n requesters (never narrower than one bit).
   function automatic int tag_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fpadd_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first eligible index at or after rr_ptr wins.
module fpadd_sched_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] eligible,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_any
);

   // Scan the search order backwards so the last hit is the first index in round-robin order.
   always_comb begin
      int idx;
      idx       = 0;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr) + k) % N_REQ;
         if (eligible[idx]) begin
            grant_any = 1'b1;
            grant_idx = IDX_W'(idx);
         end
      end
      if (grant_any) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/fpadd_sched.sv
// Round-robin scheduler sharing one fixed-latency FP32 adder between N_REQ requesters.
// Each requester may have one op outstanding; a tag pipeline routes every sum back to its owner.
module fpadd_sched
   import fpadd_sched_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int ADD_LAT = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [FP_W*N_REQ-1:0] req_a,
   input  logic [FP_W*N_REQ-1:0] req_b,
   output logic [N_REQ-1:0]      rsp_valid,
   input  logic [N_REQ-1:0]      rsp_ready,
   output logic [FP_W*N_REQ-1:0] rsp_data,
   output logic [FP_W-1:0]       add_a,
   output logic [FP_W-1:0]       add_b,
   input  logic [FP_W-1:0]       add_result,
   output logic                  busy
);

   localparam int IDX_W = tag_w(N_REQ);

   logic [N_REQ-1:0]                eligible;
   logic [N_REQ-1:0]                grant;
   logic [IDX_W-1:0]                grant_idx;
   logic                            grant_any;
   logic                            issue;

   logic [N_REQ-1:0]                pend_q, pend_d;
   logic [IDX_W-1:0]                rr_ptr_q, rr_ptr_d;
   // The issue cycle itself is the zeroth tag stage; these registers hold the in-flight stages.
   logic [ADD_LAT-1:0]              tag_valid_q, tag_valid_d;
   logic [ADD_LAT-1:0][IDX_W-1:0]   tag_idx_q, tag_idx_d;
   logic [N_REQ-1:0]                rsp_valid_q, rsp_valid_d;
   logic [N_REQ-1:0][FP_W-1:0]      rsp_data_q, rsp_data_d;

   assign eligible = req_valid & ~pend_q;

   fpadd_sched_rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .eligible  (eligible),
      .rr_ptr    (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // A grant is always a handshake because only valid requesters are eligible.
   assign issue     = grant_any & ~reset;
   assign req_ready = reset ? '0 : grant;

   // Steer the granted operand pair to the adder; idle cycles present zeros.
   always_comb begin
      add_a = '0;
      add_b = '0;
      if (issue) begin
         add_a = req_a[grant_idx*FP_W +: FP_W];
         add_b = req_b[grant_idx*FP_W +: FP_W];
      end
   end

   // Outstanding flags and round-robin pointer update.
   always_comb begin
      pend_d   = (pend_q & ~(rsp_valid_q & rsp_ready)) | (issue ? grant : '0);
      rr_ptr_d = rr_ptr_q;
      if (issue) begin
         rr_ptr_d = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // Owner tags shift alongside the adder pipeline without stalling.
   always_comb begin
      tag_valid_d    = '0;
      tag_idx_d      = '0;
      tag_valid_d[0] = issue;
      tag_idx_d[0]   = grant_idx;
      for (int s = 1; s < ADD_LAT; s++) begin
         tag_valid_d[s] = tag_valid_q[s-1];
         tag_idx_d[s]   = tag_idx_q[s-1];
      end
   end

   // Capture the adder result for its owner and retire consumed responses.
   always_comb begin
      rsp_valid_d = rsp_valid_q & ~rsp_ready;
      rsp_data_d  = rsp_data_q;
      if (tag_valid_q[ADD_LAT-1]) begin
         rsp_valid_d[tag_idx_q[ADD_LAT-1]] = 1'b1;
         rsp_data_d[tag_idx_q[ADD_LAT-1]]  = add_result;
      end
   end

   // State registers; reset discards everything in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q      <= '0;
         rr_ptr_q    <= '0;
         tag_valid_q <= '0;
         tag_idx_q   <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         pend_q      <= pend_d;
         rr_ptr_q    <= rr_ptr_d;
         tag_valid_q <= tag_valid_d;
         tag_idx_q   <= tag_idx_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp
      assign rsp_data[gi*FP_W +: FP_W] = rsp_data_q[gi];
   end

   assign rsp_valid = rsp_valid_q;
   assign busy      = (|tag_valid_q) | (|rsp_valid_q);

endmodule

// File: tb/tb_fpadd_sched.sv
// Bench for fpadd_sched: behavioural FP32 adder (latency 2) plus a queue-based scheduling model.
module tb_fpadd_sched;

   localparam int N   = 4;
   localparam int LAT = 2;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [32*N-1:0] req_a = '0;
   logic [32*N-1:0] req_b = '0;
   logic [N-1:0]    rsp_valid;
   logic [N-1:0]    rsp_ready = '0;
   logic [32*N-1:0] rsp_data;
   logic [31:0]     add_a, add_b;
   logic [31:0]     add_result = '0;
   logic            busy;

   int n_pass  = 0;
   int n_total = 0;

   fpadd_sched #(.N_REQ(N), .ADD_LAT(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_result (add_result),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // ---------------- FP32 arithmetic via double precision ----------------
   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:0] == 31'd0) d = {f[31], 63'd0};
      else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      int          e;
      logic [22:0] m;
      logic [28:0] rest;
      logic        rnd;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return 32'h0;
      e    = int'(d[62:52]) - 896;
      m    = d[51:29];
      rest = d[28:0];
      rnd  = rest[28] & ((rest[27:0] != 28'd0) | m[0]);
      if (rnd) begin
         if (m == 23'h7FFFFF) begin
            m = '0;
            e = e + 1;
         end else begin
            m = m + 1'b1;
         end
      end
      return {d[63], e[7:0], m};
   endfunction

   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      return r2f(f2r(a) + f2r(b));
   endfunction

   function automatic logic [31:0] rand_fp();
      return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
   endfunction

   // Behavioural adder: registered inputs, registered output.
   logic [31:0] am_a = '0, am_b = '0;
   always @(posedge clk) begin
      am_a       <= add_a;
      am_b       <= add_b;
      add_result <= fp_add(am_a, am_b);
   end

   // ---------------- scheduling reference model ----------------
   typedef struct {
      int          owner;
      int          due;
      logic [31:0] sum;
   } op_t;

   int          m_ptr;
   int          m_cyc;
   logic [N-1:0] m_pend;
   logic [N-1:0] m_rv;
   logic [31:0] m_rd [N];
   op_t         m_q[$];

   task automatic model_reset();
      m_ptr  = 0;
      m_cyc  = 0;
      m_pend = '0;
      m_rv   = '0;
      for (int i = 0; i < N; i++) m_rd[i] = '0;
      m_q.delete();
   endtask

   function automatic int model_grant(input logic [N-1:0] rv);
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (m_ptr + k) % N;
         if (rv[idx] && !m_pend[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] model_ready(input logic [N-1:0] rv);
      logic [N-1:0] r;
      int g;
      r = '0;
      g = model_grant(rv);
      if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   function automatic logic [32*N-1:0] model_data();
      logic [32*N-1:0] d;
      for (int i = 0; i < N; i++) d[32*i +: 32] = m_rd[i];
      return d;
   endfunction

   function automatic logic model_busy();
      return (m_q.size() != 0) || (m_rv != '0);
   endfunction

   // Advance the model across one clock edge using the inputs currently applied.
   task automatic model_advance();
      int g;
      op_t op;
      g = model_grant(req_valid);
      for (int i = 0; i < N; i++) begin
         if (m_rv[i] && rsp_ready[i]) begin
            m_rv[i]   = 1'b0;
            m_pend[i] = 1'b0;
         end
      end
      if (g >= 0) begin
         m_pend[g] = 1'b1;
         m_ptr     = (g + 1) % N;
         op.owner  = g;
         op.due    = m_cyc + LAT + 1;
         op.sum    = fp_add(req_a[32*g +: 32], req_b[32*g +: 32]);
         m_q.push_back(op);
      end
      m_cyc = m_cyc + 1;
      for (int j = m_q.size() - 1; j >= 0; j--) begin
         if (m_q[j].due == m_cyc) begin
            m_rv[m_q[j].owner] = 1'b1;
            m_rd[m_q[j].owner] = m_q[j].sum;
            m_q.delete(j);
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   task automatic pulse_reset();
      reset     = 1'b1;
      req_valid = '0;
      rsp_ready = '0;
      req_a     = '0;
      req_b     = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset     = 1'b1;
      req_valid = '1;
      for (int i = 0; i < N; i++) set_op(i, rand_fp(), rand_fp());
      tick();
      tick();
      @(negedge clk);
      n_total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else n_pass++;
      n_total++; if (add_a !== 32'h0) $display("FAIL reset_add_a: got %h want 0", add_a); else n_pass++;
      n_total++; if (add_b !== 32'h0) $display("FAIL reset_add_b: got %h want 0", add_b); else n_pass++;
      n_total++; if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); else n_pass++;
      n_total++; if (rsp_data !== '0) $display("FAIL reset_rsp_data: got %h want 0", rsp_data); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      tick();
      reset     = 1'b0;
      req_valid = '0;
      model_reset();
      @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_single();
      pulse_reset();
      req_valid = 4'b0001;
      set_op(0, 32'h3F800000, 32'h40000000);
      @(negedge clk);
      n_total++; if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b want 0001", req_ready); else n_pass++;
      n_total++; if (add_a !== 32'h3F800000) $display("FAIL single_add_a: got %h want 3f800000", add_a); else n_pass++;
      n_total++; if (add_b !== 32'h40000000) $display("FAIL single_add_b: got %h want 40000000", add_b); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL single_busy_c0: got %b want 0", busy); else n_pass++;
      tick();
      req_valid = '0;
      for (int c = 1; c < 3; c++) begin
         @(negedge clk);
         n_total++; if (rsp_valid !== 4'b0000) $display("FAIL single_early_rsp c%0d: got %b want 0000", c, rsp_valid); else n_pass++;
         n_total++; if (busy !== 1'b1) $display("FAIL single_busy c%0d: got %b want 1", c, busy); else n_pass++;
         tick();
      end
      rsp_ready = 4'b0001;
      @(negedge clk);
      n_total++; if (rsp_valid !== 4'b0001) $display("FAIL single_rsp_valid: got %b want 0001", rsp_valid); else n_pass++;
      n_total++; if (rsp_data[31:0] !== 32'h40400000) $display("FAIL single_rsp_data: got %h want 40400000", rsp_data[31:0]); else n_pass++;
      $display("single: rsp 0 data %h", rsp_data[31:0]);
      tick();
      rsp_ready = '0;
      @(negedge clk);
      n_total++; if (rsp_valid !== 4'b0000) $display("FAIL single_rsp_clear: got %b want 0000", rsp_valid); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL single_idle_busy: got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0]  ea [N];
      logic [31:0]  eb [N];
      logic [N-1:0] exp_r;
      pulse_reset();
      for (int i = 0; i < N; i++) begin
         ea[i] = rand_fp();
         eb[i] = rand_fp();
         set_op(i, ea[i], eb[i]);
      end
      req_valid = '1;
      rsp_ready = '1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         exp_r = '0;
         if (c < 4) exp_r[c] = 1'b1;
         n_total++; if (req_ready !== exp_r) $display("FAIL b2b_ready c%0d: got %b want %b", c, req_ready, exp_r); else n_pass++;
         if (c < 4) begin
            n_total++; if (add_a !== ea[c]) $display("FAIL b2b_add_a c%0d: got %h want %h", c, add_a, ea[c]); else n_pass++;
         end
         exp_r = '0;
         if (c >= 3 && c < 7) exp_r[c-3] = 1'b1;
         n_total++; if (rsp_valid !== exp_r) $display("FAIL b2b_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_r); else n_pass++;
         if (c >= 3 && c < 7) begin
            n_total++;
            if (rsp_data[32*(c-3) +: 32] !== fp_add(ea[c-3], eb[c-3]))
               $display("FAIL b2b_rsp_data c%0d: got %h want %h", c, rsp_data[32*(c-3) +: 32], fp_add(ea[c-3], eb[c-3]));
            else n_pass++;
            $display("b2b: rsp %0d data %h", c - 3, rsp_data[32*(c-3) +: 32]);
         end
         tick();
         if (c < 4) req_valid[c] = 1'b0;
      end
   endtask

   task automatic test_hold();
      int grants1;
      grants1 = 0;
      pulse_reset();
      req_valid = '1;
      rsp_ready = 4'b1101;
      for (int i = 0; i < N; i++) set_op(i, rand_fp(), rand_fp());
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         n_total++; if (req_ready !== model_ready(req_valid)) $display("FAIL hold_ready c%0d: got %b want %b", c, req_ready, model_ready(req_valid)); else n_pass++;
         n_total++; if (rsp_valid !== m_rv) $display("FAIL hold_rsp_valid c%0d: got %b want %b", c, rsp_valid, m_rv); else n_pass++;
         if (m_rv[1]) begin
            n_total++; if (req_ready[1] !== 1'b0) $display("FAIL hold_regrant c%0d: got %b want 0", c, req_ready[1]); else n_pass++;
            n_total++; if (rsp_data[63:32] !== m_rd[1]) $display("FAIL hold_data c%0d: got %h want %h", c, rsp_data[63:32], m_rd[1]); else n_pass++;
         end
         if (req_ready[1]) grants1++;
         model_advance();
         tick();
         for (int i = 0; i < N; i++) set_op(i, rand_fp(), rand_fp());
      end
      n_total++; if (grants1 !== 1) $display("FAIL hold_grant_count: got %0d want 1", grants1); else n_pass++;
   endtask

   task automatic test_same_cycle();
      pulse_reset();
      req_valid = 4'b0100;
      set_op(2, rand_fp(), rand_fp());
      @(negedge clk);
      n_total++; if (req_ready !== 4'b0100) $display("FAIL same_first: got %b want 0100", req_ready); else n_pass++;
      tick();
      req_valid = '0;
      tick();
      tick();
      rsp_ready = 4'b0100;
      req_valid = 4'b0101;
      set_op(0, rand_fp(), rand_fp());
      set_op(2, rand_fp(), rand_fp());
      @(negedge clk);
      n_total++; if (rsp_valid !== 4'b0100) $display("FAIL same_rsp: got %b want 0100", rsp_valid); else n_pass++;
      n_total++; if (req_ready !== 4'b0001) $display("FAIL same_bubble: got %b want 0001", req_ready); else n_pass++;
      tick();
      rsp_ready = '0;
      req_valid = 4'b0100;
      @(negedge clk);
      n_total++; if (req_ready !== 4'b0100) $display("FAIL same_next: got %b want 0100", req_ready); else n_pass++;
      n_total++; if (rsp_valid !== 4'b0000) $display("FAIL same_rsp_clear: got %b want 0000", rsp_valid); else n_pass++;
      tick();
      req_valid = '0;
      rsp_ready = '1;
      repeat (5) tick();
   endtask

   task automatic test_reset_inflight();
      pulse_reset();
      req_valid = 4'b0001;
      set_op(0, rand_fp(), rand_fp());
      set_op(1, rand_fp(), rand_fp());
      @(negedge clk);
      n_total++; if (req_ready !== 4'b0001) $display("FAIL rstf_grant0: got %b want 0001", req_ready); else n_pass++;
      tick();
      req_valid = 4'b0010;
      @(negedge clk);
      n_total++; if (req_ready !== 4'b0010) $display("FAIL rstf_grant1: got %b want 0010", req_ready); else n_pass++;
      tick();
      req_valid = '1;
      #2;
      n_total++; if (busy !== 1'b1) $display("FAIL rstf_busy_before: got %b want 1", busy); else n_pass++;
      reset = 1'b1;
      #1;
      n_total++; if (rsp_valid !== 4'b0000) $display("FAIL rstf_rsp_valid: got %b want 0000", rsp_valid); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL rstf_busy: got %b want 0", busy); else n_pass++;
      n_total++; if (req_ready !== 4'b0000) $display("FAIL rstf_ready: got %b want 0000", req_ready); else n_pass++;
      n_total++; if (add_a !== 32'h0) $display("FAIL rstf_add_a: got %h want 0", add_a); else n_pass++;
      tick();
      tick();
      reset     = 1'b0;
      req_valid = '0;
      model_reset();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_total++; if (rsp_valid !== 4'b0000) $display("FAIL rstf_ghost c%0d: got %b want 0000", c, rsp_valid); else n_pass++;
         n_total++; if (busy !== 1'b0) $display("FAIL rstf_ghost_busy c%0d: got %b want 0", c, busy); else n_pass++;
         tick();
      end
   endtask

   task automatic test_wrap();
      pulse_reset();
      rsp_ready = '1;
      for (int i = 0; i < N; i++) set_op(i, rand_fp(), rand_fp());
      req_valid = 4'b0100;
      @(negedge clk);
      n_total++; if (req_ready !== 4'b0100) $display("FAIL wrap_g2: got %b want 0100", req_ready); else n_pass++;
      tick();
      req_valid = 4'b1001;
      @(negedge clk);
      n_total++; if (req_ready !== 4'b1000) $display("FAIL wrap_g3: got %b want 1000", req_ready); else n_pass++;
      tick();
      req_valid = 4'b0001;
      @(negedge clk);
      n_total++; if (req_ready !== 4'b0001) $display("FAIL wrap_g0: got %b want 0001", req_ready); else n_pass++;
      tick();
      req_valid = '0;
      repeat (3) tick();
      req_valid = '1;
      @(negedge clk);
      n_total++; if (req_ready !== 4'b0010) $display("FAIL wrap_ptr1: got %b want 0010", req_ready); else n_pass++;
      tick();
      req_valid = '0;
      repeat (5) tick();
   endtask

   task automatic test_random();
      int g;
      logic [31:0] ea, eb;
      pulse_reset();
      for (int c = 0; c < 400; c++) begin
         req_valid = N'($urandom);
         rsp_ready = N'($urandom);
         for (int i = 0; i < N; i++) set_op(i, rand_fp(), rand_fp());
         @(negedge clk);
         g  = model_grant(req_valid);
         ea = (g >= 0) ? req_a[32*g +: 32] : 32'h0;
         eb = (g >= 0) ? req_b[32*g +: 32] : 32'h0;
         n_total++; if (req_ready !== model_ready(req_valid)) $display("FAIL rnd_ready c%0d: got %b want %b", c, req_ready, model_ready(req_valid)); else n_pass++;
         n_total++; if (add_a !== ea) $display("FAIL rnd_add_a c%0d: got %h want %h", c, add_a, ea); else n_pass++;
         n_total++; if (add_b !== eb) $display("FAIL rnd_add_b c%0d: got %h want %h", c, add_b, eb); else n_pass++;
         n_total++; if (rsp_valid !== m_rv) $display("FAIL rnd_rsp_valid c%0d: got %b want %b", c, rsp_valid, m_rv); else n_pass++;
         n_total++; if (rsp_data !== model_data()) $display("FAIL rnd_rsp_data c%0d: got %h want %h", c, rsp_data, model_data()); else n_pass++;
         n_total++; if (busy !== model_busy()) $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, model_busy()); else n_pass++;
         if (g >= 0) begin
            n_total++; if (rsp_valid[g] !== 1'b0) $display("FAIL rnd_collision c%0d: rsp_valid[%0d] got %b want 0", c, g, rsp_valid[g]); else n_pass++;
         end
         for (int i = 0; i < N; i++) begin
            if (m_rv[i] && rsp_ready[i]) $display("rnd c%0d: rsp %0d data %h", c, i, m_rd[i]);
         end
         model_advance();
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_hold();
      test_same_cycle();
      test_reset_inflight();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
